bcd_7seg_scan: RTL and testbench

//  Drives a 4-digit common-anode 7-segment display. Sits directly downstream of bin2bcd
//  and consumes its thousands/hundreds/tens/ones digits. Time-multiplexes the digits with a

---
 rtl/bcd_7seg_scan.sv | 144 ++++++++++++++
 tb/tb_bcd_7seg_scan.sv | 129 ++++++++++++
 2 files changed

// File: rtl/bcd_7seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_7seg_scan
// Description : 4-digit common-anode 7-segment scanner. Snapshots the BCD
//               digits once per frame, time-multiplexes them with a prescaled
//               scan, inserts a dark guard at the start of every slot and
//               blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_7seg_scan #(
  parameter int DIV   = 50000,
  parameter int GUARD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [3:0] dp_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int              CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   C_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]   C_GUARD = CW'(GUARD);
  localparam logic [6:0]      C_DARK  = 7'h7F;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_sh_th, r_sh_hu, r_sh_te, r_sh_on;
  logic [3:0]    r_sh_dp;
  logic          w_tick;
  logic          w_snap;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_start;

  // Segment pattern {g,f,e,d,c,b,a}, active low; invalid BCD shows a dash.
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h3F;
    endcase
  endfunction

  assign w_tick = (r_cnt == C_LAST);
  assign w_snap = w_tick && (r_idx == 2'd3);

  // Prescaler and digit index: advance to the next digit at the end of each slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_idx <= r_idx + 2'd1;
    end
  end

  // Frame snapshot: inputs are captured only at the end of the thousands slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_th       <= 4'd0;
      r_sh_hu       <= 4'd0;
      r_sh_te       <= 4'd0;
      r_sh_on       <= 4'd0;
      r_sh_dp       <= 4'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_snap;
      if (w_snap) begin
        r_sh_th <= thousands;
        r_sh_hu <= hundreds;
        r_sh_te <= tens;
        r_sh_on <= ones;
        r_sh_dp <= dp_sel;
      end
    end
  end

  // Select the current digit and decide whether it is a leading zero.
  always_comb begin
    w_digit = r_sh_on;
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin
        w_digit = r_sh_on;
        w_blank = 1'b0;
      end
      2'd1: begin
        w_digit = r_sh_te;
        w_blank = (r_sh_th == 4'd0) && (r_sh_hu == 4'd0) && (r_sh_te == 4'd0);
      end
      2'd2: begin
        w_digit = r_sh_hu;
        w_blank = (r_sh_th == 4'd0) && (r_sh_hu == 4'd0);
      end
      default: begin
        w_digit = r_sh_th;
        w_blank = (r_sh_th == 4'd0);
      end
    endcase
  end

  // Registered pin drive: dark during the guard, otherwise the selected digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'b1111;
      r_seg <= C_DARK;
      r_dp  <= 1'b1;
    end else if (r_cnt < C_GUARD) begin
      r_an  <= 4'b1111;
      r_seg <= C_DARK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_blank ? C_DARK : enc(w_digit);
      r_dp  <= ~r_sh_dp[r_idx];
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_bcd_7seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_7seg_scan
// Description : Directed self-checking bench for bcd_7seg_scan (DIV=8, GUARD=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_7seg_scan;

  logic       clk;
  logic       rst_n;
  logic [3:0] thousands, hundreds, tens, ones, dp_sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int errors = 0;
  int checks = 0;

  bcd_7seg_scan #(.DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
    .dp_sel(dp_sel),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check the 8 cycles of one slot; the last slot of a frame ends with frame_start.
  task automatic check_slot(input string tag, input int idx, input logic [6:0] s,
                            input logic d, input bit last);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c < 2) begin
        chk({tag, "_guard_an"},  {4'h0, an},  8'h0F);
        chk({tag, "_guard_seg"}, {1'b0, seg}, 8'h7F);
        chk({tag, "_guard_dp"},  {7'h0, dp},  8'h01);
      end else begin
        chk({tag, "_an"},  {4'h0, an},  {4'h0, ~(4'b0001 << idx)});
        chk({tag, "_seg"}, {1'b0, seg}, {1'b0, s});
        chk({tag, "_dp"},  {7'h0, dp},  {7'h0, d});
      end
      chk({tag, "_fs"}, {7'h0, frame_start}, {7'h0, (last && c == 7)});
    end
  endtask

  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] d);
    check_slot({tag, "_ones"}, 0, s0, d[0], 1'b0);
    check_slot({tag, "_tens"}, 1, s1, d[1], 1'b0);
    check_slot({tag, "_hund"}, 2, s2, d[2], 1'b0);
    check_slot({tag, "_thou"}, 3, s3, d[3], 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    thousands = 4'd9; hundreds = 4'd9; tens = 4'd9; ones = 4'd9; dp_sel = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an",  {4'h0, an},  8'h0F);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp",  {7'h0, dp},  8'h01);
    chk("rst_fs",  {7'h0, frame_start}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Power-up frame shows "   0"; snapshot of 9999 lands at cycle 32.
    check_frame("boot", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1111);

    // 9999 displayed; load 0010 for the next frame.
    thousands = 4'd0; hundreds = 4'd0; tens = 4'd1; ones = 4'd0;
    check_frame("n9999", 7'h10, 7'h10, 7'h10, 7'h10, 4'b1111);

    // 0010 displayed with two blanked leading digits; queue 1234.
    thousands = 4'd1; hundreds = 4'd2; tens = 4'd3; ones = 4'd4;
    check_frame("n0010", 7'h40, 7'h79, 7'h7F, 7'h7F, 4'b1111);

    // 1234 displayed; switching to 5678 mid-frame must not disturb it.
    check_slot("n1234_ones", 0, 7'h19, 1'b1, 1'b0);
    check_slot("n1234_tens", 1, 7'h30, 1'b1, 1'b0);
    thousands = 4'd5; hundreds = 4'd6; tens = 4'd7; ones = 4'd8;
    check_slot("n1234_hund", 2, 7'h24, 1'b1, 1'b0);
    check_slot("n1234_thou", 3, 7'h79, 1'b1, 1'b1);

    // 5678 displayed; queue invalid thousands with hundreds decimal point.
    thousands = 4'hC; hundreds = 4'd0; tens = 4'd0; ones = 4'd0; dp_sel = 4'b0100;
    check_frame("n5678", 7'h00, 7'h78, 7'h02, 7'h12, 4'b1111);

    // Invalid nibble counts as nonzero, so nothing below it is blanked.
    check_frame("nC000", 7'h40, 7'h40, 7'h40, 7'h3F, 4'b1011);

    // Reset mid-slot: outputs dark without a clock edge.
    check_slot("pre_rst_ones", 0, 7'h40, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    chk("midslot_an_lit", {4'h0, an}, 8'h0D);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an",  {4'h0, an},  8'h0F);
    chk("async_rst_seg", {1'b0, seg}, 8'h7F);
    chk("async_rst_dp",  {7'h0, dp},  8'h01);
    @(negedge clk);
    rst_n = 1'b1;

    // Scan restarts at the ones digit with cleared shadow registers.
    check_frame("restart", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
